imm_encoder: RTL and testbench
==============================

Name: imm_encoder

Overview:
- Sequential encoder from a 32-bit constant to an ARM data-processing rotated immediate: 12-bit shift_operand = {rot[3:0], imm8[7:0]}, with value = ROR(zero_ext(imm8), 2*rot).
- This is the inverse of the operand-2 immediate expansion done in the EXE stage.
- Used by the instruction-patch / self-test loader to build immediate-form instructions. It flags constants that have no encoding.
- Searches rotations iteratively; start/done handshake.

Parameters:
CHECKS_PER_CYCLE, 1, rotations tested per clock; legal values 1, 2, 4, 8, 16. Search takes at most 16/CHECKS_PER_CYCLE cycles.

Ports:
clk  input  1  clock, all state updates on rising edge
rst  input  1  asynchronous active-high reset
start  input  1  request; sampled only when busy=0
value  input  32  constant to encode; captured on the accepted start edge
busy  output  1  high while a search is in progress
done  output  1  one-cycle pulse when results are updated
valid  output  1  1 = encodable; meaningful from done onward
imm8  output  8  encoded 8-bit immediate
rot  output  4  encoded rotate field (rotation amount = 2*rot)
shift_operand  output  12  {rot, imm8}, ready for instruction bits [11:0]

Behaviour:
- Reset (async, rst=1): state IDLE; busy=0, done=0, valid=0, imm8=0, rot=0, shift_operand=0; internal value register and rotation counter cleared. Reset during SEARCH aborts with no done pulse.
- States:
  - IDLE: busy=0. On an edge with start=1: latch value, rotation counter rc=0, go to SEARCH.
  - SEARCH: busy=1. Each cycle test rotations rc .. rc+CHECKS_PER_CYCLE-1.
- Hit test for rotation r: ROL(value_reg, 2*r)[31:8] == 0. Among hits tested in the cycle, the lowest r wins.
- Hit at the edge:
  - imm8 <= ROL(value_reg, 2*r)[7:0], rot <= r, valid <= 1, done <= 1.
  - Return to IDLE.
- No hit:
  - If rc+CHECKS_PER_CYCLE == 16: imm8 <= 0, rot <= 0, valid <= 0, done <= 1, return to IDLE.
  - Otherwise rc <= rc+CHECKS_PER_CYCLE.
- The smallest encodable rot is always reported (canonical encoding). value=0 encodes as rot=0, imm8=0.
- Latency with CHECKS_PER_CYCLE=1: start accepted at edge E0; hit at rotation k makes done high for the cycle after edge E0+1+k. Worst case is done after E0+16.
- done is high for exactly one cycle. valid, imm8, rot and shift_operand hold until the next done or reset.
- shift_operand is always {rot, imm8} (combinational from the registered outputs).
- start while busy=1 is ignored; no queueing. Changes on value while busy do not affect the search.
- start=1 in the cycle done=1 is accepted, because the block is already in IDLE. Back-to-back requests have no dead cycle.
- Rotation arithmetic is modulo 32: a rotation of 2*r uses 5 bits, so r=15 gives a 30-bit rotation.

Test Plan:
- value=0x000000FF, C=1 → done after E0+1; valid=1, rot=0, imm8=0xFF, shift_operand=0x0FF; busy high exactly 1 cycle.
- value=0xFF000000 → rot=4, imm8=0xFF, done after E0+5. value=0xF000000F → rot=2, imm8=0xFF, done after E0+3.
- value=0x00000104 → rot=15, imm8=0x41, done after E0+16 (worst-case hit). value=0x00000101 → done after E0+16, valid=0, imm8=0, rot=0.
- Pulse start again 3 cycles into a search with a different value → ignored; original result reported. Then start in the done cycle with 0x00000000 → accepted; next done gives valid=1, shift_operand=0x000.
- Assert rst mid-SEARCH → all outputs 0 immediately (asynchronous); no done pulse; a later start behaves normally.
- CHECKS_PER_CYCLE=4: 0x00000104 → done after E0+4, rot=15. 0xFF000000 → done after E0+2, rot=4. Also random 32-bit values compared against a reference model, including the check that ROR(imm8, 2*rot)==value when valid=1.

Source files
------------

// File: rtl/imm_encoder.sv
// Iterative encoder from a 32-bit constant to an ARM rotated immediate {rot, imm8}.
// Tests CHECKS_PER_CYCLE rotations per clock; reports the smallest encodable rot.
//
//   state  | meaning
//   IDLE   | waiting for start; outputs hold the last result
//   SEARCH | testing rotations rc .. rc+CHECKS_PER_CYCLE-1 each cycle
module imm_encoder #(
  parameter int CHECKS_PER_CYCLE = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [31:0] value,
  output logic        busy,
  output logic        done,
  output logic        valid,
  output logic [7:0]  imm8,
  output logic [3:0]  rot,
  output logic [11:0] shift_operand
);

  typedef enum logic {IDLE, SEARCH} state_t;

  localparam logic [4:0] STEP5 = 5'(CHECKS_PER_CYCLE);
  localparam logic [3:0] STEP4 = STEP5[3:0];

  state_t      state;
  logic [31:0] value_reg;
  logic [3:0]  rc;

  logic        hit;
  logic [3:0]  hit_rot;
  logic [7:0]  hit_imm;
  logic [3:0]  cand;
  logic [31:0] rotated;
  logic        last_group;

  function automatic logic [31:0] rol32(input logic [31:0] x, input logic [4:0] s);
    logic [63:0] t;
    t = {x, x} << s;
    return t[63:32];
  endfunction

  // Lowest rotation in this cycle's group whose rotated value fits in 8 bits wins.
  always_comb begin
    hit     = 1'b0;
    hit_rot = '0;
    hit_imm = '0;
    cand    = '0;
    rotated = '0;
    for (int i = 0; i < CHECKS_PER_CYCLE; i++) begin
      cand    = rc + 4'(i);
      rotated = rol32(value_reg, {cand, 1'b0});
      if (!hit && rotated[31:8] == 24'd0) begin
        hit     = 1'b1;
        hit_rot = cand;
        hit_imm = rotated[7:0];
      end
    end
  end

  assign last_group    = (({1'b0, rc} + STEP5) == 5'd16);
  assign shift_operand = {rot, imm8};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      value_reg <= '0;
      rc        <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
      valid     <= 1'b0;
      imm8      <= '0;
      rot       <= '0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            value_reg <= value;
            rc        <= '0;
            busy      <= 1'b1;
            state     <= SEARCH;
          end
        end
        SEARCH: begin
          if (hit) begin
            imm8  <= hit_imm;
            rot   <= hit_rot;
            valid <= 1'b1;
            done  <= 1'b1;
            busy  <= 1'b0;
            state <= IDLE;
          end else if (last_group) begin
            imm8  <= '0;
            rot   <= '0;
            valid <= 1'b0;
            done  <= 1'b1;
            busy  <= 1'b0;
            state <= IDLE;
          end else begin
            rc <= rc + STEP4;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_imm_encoder.sv
// Bench for imm_encoder: two instances (1 and 4 checks per cycle) compared every
// cycle against a brute-force encoding model, plus hand-computed directed cases.
module tb_imm_encoder;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start_v [2];
  logic [31:0] val_v   [2];
  logic        busy_v  [2];
  logic        done_v  [2];
  logic        valid_v [2];
  logic [7:0]  imm_v   [2];
  logic [3:0]  rot_v   [2];
  logic [11:0] so_v    [2];

  int checks = 0;
  int errors = 0;
  int cpc [2] = '{1, 4};

  always #5 clk = ~clk;

  imm_encoder #(.CHECKS_PER_CYCLE(1)) dut1 (
    .clk(clk), .rst(rst), .start(start_v[0]), .value(val_v[0]),
    .busy(busy_v[0]), .done(done_v[0]), .valid(valid_v[0]),
    .imm8(imm_v[0]), .rot(rot_v[0]), .shift_operand(so_v[0])
  );

  imm_encoder #(.CHECKS_PER_CYCLE(4)) dut4 (
    .clk(clk), .rst(rst), .start(start_v[1]), .value(val_v[1]),
    .busy(busy_v[1]), .done(done_v[1]), .valid(valid_v[1]),
    .imm8(imm_v[1]), .rot(rot_v[1]), .shift_operand(so_v[1])
  );

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] ror(input logic [31:0] x, input int s);
    logic [63:0] t;
    t = {x, x} >> (s % 32);
    return t[31:0];
  endfunction

  // Brute force: try every rot, take the low byte that would rotate back into place,
  // and accept the first rot whose expansion reproduces the constant exactly.
  function automatic logic [12:0] ref_enc(input logic [31:0] v);
    logic [31:0] imm;
    for (int r = 0; r < 16; r++) begin
      imm = ror(v, 32 - 2 * r) & 32'hFF;
      if (ror(imm, 2 * r) == v) return {1'b1, 4'(r), imm[7:0]};
    end
    return 13'd0;
  endfunction

  // Cycle model
  logic        m_busy  [2];
  logic        m_done  [2];
  logic        m_valid [2];
  logic [3:0]  m_rot   [2];
  logic [7:0]  m_imm   [2];
  logic [12:0] m_pend  [2];
  int          m_cnt   [2];

  initial begin
    for (int k = 0; k < 2; k++) begin
      m_busy[k] = 0; m_done[k] = 0; m_valid[k] = 0; m_rot[k] = 0; m_imm[k] = 0;
      m_pend[k] = 0; m_cnt[k] = 0;
    end
    forever begin
      @(posedge clk);
      for (int k = 0; k < 2; k++) begin
        if (rst) begin
          m_busy[k] = 0; m_done[k] = 0; m_valid[k] = 0; m_rot[k] = 0; m_imm[k] = 0;
          m_cnt[k] = 0;
        end else begin
          m_done[k] = 0;
          if (m_busy[k]) begin
            m_cnt[k]--;
            if (m_cnt[k] == 0) begin
              m_busy[k]  = 0;
              m_done[k]  = 1;
              m_valid[k] = m_pend[k][12];
              m_rot[k]   = m_pend[k][11:8];
              m_imm[k]   = m_pend[k][7:0];
            end
          end else if (start_v[k]) begin
            m_pend[k] = ref_enc(val_v[k]);
            m_busy[k] = 1;
            m_cnt[k]  = m_pend[k][12] ? (int'(m_pend[k][11:8]) / cpc[k]) + 1 : 16 / cpc[k];
          end
        end
      end
      #1;
      for (int k = 0; k < 2; k++) begin
        chk($sformatf("cyc%0d_busy", k), 32'(busy_v[k]), 32'(m_busy[k]));
        chk($sformatf("cyc%0d_done", k), 32'(done_v[k]), 32'(m_done[k]));
        chk($sformatf("cyc%0d_valid", k), 32'(valid_v[k]), 32'(m_valid[k]));
        chk($sformatf("cyc%0d_rot", k), 32'(rot_v[k]), 32'(m_rot[k]));
        chk($sformatf("cyc%0d_imm8", k), 32'(imm_v[k]), 32'(m_imm[k]));
        chk($sformatf("cyc%0d_shop", k), 32'(so_v[k]), 32'({m_rot[k], m_imm[k]}));
      end
    end
  end

  // Called at posedge+1; lat < 0 skips the literal expectations.
  task automatic run(input int k, input logic [31:0] v, input int lat, input logic ev,
                     input logic [3:0] er, input logic [7:0] ei, input int poke_at,
                     input string nm);
    int n;
    logic got;
    start_v[k] = 1'b1;
    val_v[k]   = v;
    @(posedge clk);
    #1;
    start_v[k] = 1'b0;
    n = 0;
    got = 1'b0;
    while (!got && n < 40) begin
      @(posedge clk);
      #1;
      n++;
      if (done_v[k]) got = 1'b1;
      else if (n == poke_at) begin
        start_v[k] = 1'b1;
        val_v[k]   = 32'h000000FF;
      end else if (n == poke_at + 1) start_v[k] = 1'b0;
    end
    chk({nm, "_done_seen"}, 32'(got), 32'd1);
    if (lat >= 0) begin
      chk({nm, "_latency"}, n, lat);
      chk({nm, "_valid"}, 32'(valid_v[k]), 32'(ev));
      chk({nm, "_rot"}, 32'(rot_v[k]), 32'(er));
      chk({nm, "_imm8"}, 32'(imm_v[k]), 32'(ei));
      chk({nm, "_shop"}, 32'(so_v[k]), 32'({er, ei}));
    end
    if (valid_v[k]) chk({nm, "_ror_back"}, ror(32'(imm_v[k]), 2 * int'(rot_v[k])), v);
  endtask

  initial begin
    int pulses;
    logic [31:0] rv;
    start_v[0] = 0; start_v[1] = 0; val_v[0] = 0; val_v[1] = 0;
    #1;
    chk("reset_valid", 32'(valid_v[0]), 32'd0);
    chk("reset_shop", 32'(so_v[0]), 32'd0);
    repeat (2) @(posedge clk);
    #3 rst = 1'b0;
    @(posedge clk);
    #1;

    run(0, 32'h000000FF, 1, 1'b1, 4'd0, 8'hFF, 0, "c1_ff");
    run(0, 32'hFF000000, 5, 1'b1, 4'd4, 8'hFF, 0, "c1_ff000000");
    run(0, 32'hF000000F, 3, 1'b1, 4'd2, 8'hFF, 0, "c1_f000000f");
    run(0, 32'h00000104, 16, 1'b1, 4'd15, 8'h41, 0, "c1_104");
    run(0, 32'h00000101, 16, 1'b0, 4'd0, 8'h00, 0, "c1_101");
    run(0, 32'h00000104, 16, 1'b1, 4'd15, 8'h41, 3, "c1_ignore");
    run(0, 32'h00000000, 1, 1'b1, 4'd0, 8'h00, 0, "c1_chain_zero");
    run(0, 32'hFF000000, 5, 1'b1, 4'd4, 8'hFF, 0, "c1_pre_reset");

    // Abort a search with an asynchronous reset.
    start_v[0] = 1'b1;
    val_v[0]   = 32'h00000104;
    @(posedge clk);
    #1 start_v[0] = 1'b0;
    repeat (4) @(posedge clk);
    #3 rst = 1'b1;
    #1;
    chk("async_busy", 32'(busy_v[0]), 32'd0);
    chk("async_valid", 32'(valid_v[0]), 32'd0);
    chk("async_rot", 32'(rot_v[0]), 32'd0);
    chk("async_imm8", 32'(imm_v[0]), 32'd0);
    chk("async_shop", 32'(so_v[0]), 32'd0);
    @(posedge clk);
    #3 rst = 1'b0;
    pulses = 0;
    repeat (20) begin
      @(posedge clk);
      #1;
      if (done_v[0]) pulses++;
    end
    chk("abort_no_done", pulses, 0);
    run(0, 32'h000003FC, 16, 1'b1, 4'd15, 8'hFF, 0, "c1_after_reset");

    run(1, 32'h00000104, 4, 1'b1, 4'd15, 8'h41, 0, "c4_104");
    run(1, 32'hFF000000, 2, 1'b1, 4'd4, 8'hFF, 0, "c4_ff000000");
    run(1, 32'h00000101, 4, 1'b0, 4'd0, 8'h00, 0, "c4_101");
    run(1, 32'h00000000, 1, 1'b1, 4'd0, 8'h00, 0, "c4_zero");

    for (int i = 0; i < 12; i++) begin
      if (i % 2 == 0) rv = ror(32'($urandom_range(255)), 2 * int'($urandom_range(15)));
      else rv = $urandom;
      run(0, rv, -1, 1'b0, 4'd0, 8'd0, 0, "c1_rand");
      run(1, rv, -1, 1'b0, 4'd0, 8'd0, 0, "c4_rand");
    end

    repeat (2) @(posedge clk);
    #2;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
